// File: rtl/serial_cla_add_ctrl_pkg.sv
// Shared types and constants for the digit-serial CLA adder controller.
package serial_cla_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DIG_W = 2;

  function automatic int ndig_f(input int width);
    return width / DIG_W;
  endfunction

endpackage

// File: rtl/serial_cla_add_ctrl_if.sv
// Operand/sum handshake bundle for serial_cla_add_ctrl.
interface serial_cla_add_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, busy
  );

endinterface

// File: rtl/serial_cla_add_ctrl_cla2_slice.sv
// Combinational 2-bit carry-lookahead digit; APPROX_LSB_EN adds a lower-part-OR
// approximation mode selected by approx_i.
module cla2_slice
  import serial_cla_add_ctrl_pkg::*;
(
  input  logic [DIG_W-1:0] a_i,
  input  logic [DIG_W-1:0] b_i,
  input  logic             c_i,
`ifdef APPROX_LSB_EN
  input  logic             approx_i,
`endif
  output logic [DIG_W-1:0] s_o,
  output logic             c_o
);

  logic [DIG_W-1:0] g;
  logic [DIG_W-1:0] p;
  logic [DIG_W:0]   c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i | b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    s_o  = a_i ^ b_i ^ c[DIG_W-1:0];
    c_o  = c[DIG_W];
`ifdef APPROX_LSB_EN
    // Approximate digit: OR the operand bits, carry only from the top bit pair.
    if (approx_i) begin
      s_o = p;
      c_o = g[1];
    end
`endif
  end

endmodule

// File: rtl/serial_cla_add_ctrl.sv
// Digit-serial adder: one cla2_slice swept LSB-first across WIDTH-bit operands.
// Optional APPROX_LSB_EN macro approximates the low APPROX_DIGITS digits.
module serial_cla_add_ctrl
  import serial_cla_add_ctrl_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int APPROX_DIGITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_cla_add_ctrl_if.slave bus
);

  localparam int NDIG  = ndig_f(WIDTH);
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 2 || (WIDTH % 2) != 0 || APPROX_DIGITS < 0 || APPROX_DIGITS > NDIG) begin : g_bad_param
    $error("serial_cla_add_ctrl: illegal WIDTH/APPROX_DIGITS");
  end

  state_e                   state_q;
  logic [WIDTH-1:0]         a_q;
  logic [WIDTH-1:0]         b_q;
  logic [WIDTH-1:0]         sum_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     carry_q;
  logic [WIDTH:0]           out_sum_q;

  logic [DIG_W-1:0]         dig_s_d;
  logic                     carry_d;
  logic [WIDTH+DIG_W-1:0]   sum_cat_d;
  logic [WIDTH-1:0]         sum_d;
  logic                     last_dig_d;

  // New digit enters the sum register from the top.
  assign sum_cat_d  = {dig_s_d, sum_q};
  assign sum_d      = sum_cat_d[WIDTH+DIG_W-1:DIG_W];
  assign last_dig_d = (cnt_q == CNT_W'(NDIG - 1));

`ifdef APPROX_LSB_EN
  logic approx_sel;
  assign approx_sel = (int'(cnt_q) < APPROX_DIGITS);
`endif

  cla2_slice u_slice (
    .a_i      (a_q[DIG_W-1:0]),
    .b_i      (b_q[DIG_W-1:0]),
    .c_i      (carry_q),
`ifdef APPROX_LSB_EN
    .approx_i (approx_sel),
`endif
    .s_o      (dig_s_d),
    .c_o      (carry_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      out_sum_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> DIG_W;
          b_q     <= b_q >> DIG_W;
          sum_q   <= sum_d;
          carry_q <= carry_d;
          if (last_dig_d) begin
            out_sum_q <= {carry_d, sum_d};
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.out_sum   = out_sum_q;

endmodule

// File: tb/tb_serial_cla_add_ctrl.sv
// Bench for serial_cla_add_ctrl: directed table, handshake corner cases,
// random sweep against an arithmetic reference, and a WIDTH=2 instance.
module tb_serial_cla_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_cla_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_cla_add_ctrl_if #(.WIDTH(2)) bus2 ();

  serial_cla_add_ctrl #(.WIDTH(8), .APPROX_DIGITS(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_cla_add_ctrl #(.WIDTH(2), .APPROX_DIGITS(0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: low ad digits are OR-ed with carry a&b of the top low bit; the rest adds normally.
  function automatic int unsigned ref_sum(input int unsigned a, input int unsigned b, input int ad);
    int lo_bits;
    int unsigned mask, lo, c, hi;
`ifdef APPROX_LSB_EN
    lo_bits = 2 * ad;
`else
    lo_bits = 0 * ad;
`endif
    if (lo_bits == 0) return a + b;
    mask = (32'd1 << lo_bits) - 1;
    lo   = (a | b) & mask;
    c    = (a >> (lo_bits - 1)) & (b >> (lo_bits - 1)) & 1;
    hi   = (a >> lo_bits) + (b >> lo_bits) + c;
    return (hi << lo_bits) | lo;
  endfunction

  task automatic add8(input logic [7:0] a, input logic [7:0] b, input string name,
                      output logic [8:0] res);
    int lat;
    @(negedge clk);
    bus8.in_a     = a;
    bus8.in_b     = b;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 20) begin
      check({name, "_in_ready_run"}, bus8.in_ready, 0);
      check({name, "_busy_run"}, bus8.busy, 1);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, "_latency"}, lat, 4);
    check({name, "_in_ready_done"}, bus8.in_ready, 0);
    res = bus8.out_sum;
    if (bus8.out_ready) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_out_valid_after"}, bus8.out_valid, 0);
      check({name, "_in_ready_after"}, bus8.in_ready, 1);
    end
  endtask

  task automatic add2(input logic [1:0] a, input logic [1:0] b, input string name,
                      output logic [2:0] res);
    int lat;
    @(negedge clk);
    bus2.in_a     = a;
    bus2.in_b     = b;
    bus2.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    lat = 0;
    while (!bus2.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, "_latency"}, lat, 1);
    res = bus2.out_sum;
    @(posedge clk);
    @(negedge clk);
    check({name, "_in_ready_after"}, bus2.in_ready, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [8:0] r8;
    logic [2:0] r2;
    logic [7:0] ra, rb;

    tbl[0] = '{8'hFF, 8'h01, 9'h100};
    tbl[1] = '{8'hAA, 8'h55, 9'h0FF};
    tbl[2] = '{8'h00, 8'h00, 9'h000};
    tbl[3] = '{8'h80, 8'h80, 9'h100};
    tbl[4] = '{8'h12, 8'h34, 9'h046};
`ifdef APPROX_LSB_EN
    tbl[0] = '{8'hFF, 8'h01, 9'h0FF};
    tbl[5] = '{8'h03, 8'h01, 9'h003};
    tbl[6] = '{8'h0F, 8'h01, 9'h00F};
`else
    tbl[5] = '{8'h03, 8'h01, 9'h004};
    tbl[6] = '{8'h0F, 8'h01, 9'h010};
`endif

    rst            = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.in_a      = '0;
    bus8.in_b      = '0;
    bus8.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_a      = '0;
    bus2.in_b      = '0;
    bus2.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus8.in_ready, 1);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_out_sum", bus8.out_sum, 0);
    check("rst_busy", bus8.busy, 0);
    check("rst_w2_in_ready", bus2.in_ready, 1);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      add8(tbl[i].a, tbl[i].b, $sformatf("tbl%0d", i), r8);
      check($sformatf("tbl%0d_sum", i), r8, tbl[i].exp);
    end

    // Backpressure: result held in DONE, new operands refused.
    bus8.out_ready = 1'b0;
    add8(8'h80, 8'h80, "bp", r8);
    check("bp_sum", r8, ref_sum(8'h80, 8'h80, 1));
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = 1'b1;
      bus8.in_a     = 8'h11;
      bus8.in_b     = 8'h22;
      check("bp_out_valid", bus8.out_valid, 1);
      check("bp_out_sum_hold", bus8.out_sum, 9'h100);
      check("bp_in_ready", bus8.in_ready, 0);
      @(posedge clk);
      @(negedge clk);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_rel_out_valid", bus8.out_valid, 0);
    check("bp_rel_in_ready", bus8.in_ready, 1);
    check("bp_rel_busy", bus8.busy, 0);

    // Reset during the second RUN cycle aborts the add.
    @(negedge clk);
    bus8.in_a     = 8'h77;
    bus8.in_b     = 8'h11;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", bus8.in_ready, 1);
    check("abort_out_valid", bus8.out_valid, 0);
    check("abort_out_sum", bus8.out_sum, 0);
    check("abort_busy", bus8.busy, 0);
    add8(8'h12, 8'h34, "post_abort", r8);
    check("post_abort_sum", r8, 9'h046);

    // Random sweep against the arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      add8(ra, rb, "rnd", r8);
      check($sformatf("rnd_%02h_%02h", ra, rb), r8, ref_sum(ra, rb, 1));
    end

    // WIDTH=2 instance: single RUN cycle, exhaustive.
    add2(2'd3, 2'd3, "w2_3p3", r2);
    check("w2_3p3_sum", r2, 3'd6);
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        add2(2'(a), 2'(b), "w2", r2);
        check($sformatf("w2_%0d_%0d", a, b), r2, a + b);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/serial_cla_add_ctrl.md
Name: serial_cla_add_ctrl

Overview:
- Digit-serial adder controller. Accepts a pair of WIDTH-bit operands over a valid/ready handshake.
- Sequences a single 2-bit carry-lookahead slice across the operands, least-significant digit first, one digit per cycle.
- Registers the carry between digits and presents the (WIDTH+1)-bit sum on a valid/ready output.
- Lets wide adds share one small CLA slice in the adder characterisation flow.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. NDIG = WIDTH/2 digits.
- APPROX_DIGITS, 1, number of low digits approximated when APPROX_LSB_EN is defined; range 0..NDIG; ignored otherwise.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  sum valid
- out_ready  in  1  consumer accepts sum
- out_sum  out  WIDTH+1  A+B; MSB is the final carry
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (synchronous, rst=1 at a clock edge), effective next cycle:
  - state=IDLE; in_ready=1; out_valid=0; out_sum=0; busy=0.
  - Internal shift registers, digit counter and carry are cleared.
  - Reset mid-operation aborts the add with no output; the operand pair is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_a/in_b into shift registers, carry=0, digit count=0, go to RUN.
  - in_valid without the handshake has no effect.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle the slice adds the low 2 bits of each shift register plus the carry.
  - The 2 sum bits shift into the sum register from the top; the operands shift right by 2; the slice carry-out is registered.
  - After digit NDIG-1: load out_sum={carry, sum_reg}, go to DONE.
- DONE:
  - out_valid=1; out_sum is held stable until the handshake.
  - On out_ready=1: out_valid drops next cycle and state=IDLE.
  - out_ready while not in DONE is ignored.
- Latency: out_valid rises exactly NDIG cycles after the accepting edge (WIDTH=8: 4 cycles).
- Throughput: no overlap of operations. With out_ready tied high, one add completes per NDIG+2 cycles.
- Arithmetic:
  - Unsigned; no overflow is possible because the result is WIDTH+1 bits.
  - Carry-in to digit 0 is always 0.
  - Digit slice: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | (a[i]|b[i])&c[i].
- Boundary: the digit counter is log2(NDIG)-wide minimum with no wrap. WIDTH=2 gives NDIG=1, a single RUN cycle.

Optional Feature:
- Macro APPROX_LSB_EN.
- Defined: lower-part-OR approximation for digits 0..APPROX_DIGITS-1.
  - Sum bits = a|b per bit, carry ignored.
  - Carry out of the digit = a[1]&b[1].
  - Higher digits are exact.
  - APPROX_DIGITS=0 behaves exactly.
- Not defined: all digits exact and APPROX_DIGITS has no effect. No approximation logic is synthesised.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/RUN/DONE), 2-bit encoding.
  - Digit width constant DIG_W=2.
  - Function computing NDIG from WIDTH.
- Sub-module cla2_slice, purely combinational:
  - Inputs: 2-bit a, 2-bit b, carry-in, approx-select.
  - Outputs: 2-bit sum, carry-out.
  - Generate/propagate CLA equations as above.
  - The approx-select path exists only under APPROX_LSB_EN.
- The controller instantiates exactly one cla2_slice.

Test Plan:
- WIDTH=8, A=0xFF, B=0x01, out_ready=1 → out_valid 4 cycles after accept, out_sum=0x100, in_ready high again the following cycle.
- A=0xAA, B=0x55 → out_sum=0x0FF. Then A=0x00, B=0x00 → 0x000, with in_ready=0 throughout RUN/DONE.
- Backpressure, out_ready=0 for 5 cycles in DONE with A=0x80, B=0x80:
  - out_sum=0x100 held stable with out_valid=1.
  - in_valid pulses during this window are not accepted.
  - Release out_ready → IDLE next cycle.
- rst asserted during the 2nd RUN cycle:
  - Next cycle: IDLE, out_valid=0, out_sum=0.
  - A new add A=0x12, B=0x34 then yields 0x046.
- APPROX_LSB_EN defined, APPROX_DIGITS=1:
  - A=0x03, B=0x01 → 0x003 (exact would be 0x004).
  - A=0x0F, B=0x01 → 0x00F.
  - Same vectors without the macro → 0x004 and 0x010.
- Random sweep, 1000 pairs, WIDTH=8 exact build → out_sum equals A+B every time. Repeat with WIDTH=2, A=3, B=3 → 0x6 after 1 cycle.
